sysid_boot_checker: RTL and testbench

Avalon-MM master that sits directly upstream of the system-ID slave. After reset, or on request, it reads the slave's two words: address 0 (system ID) and address 1 (build timestamp). It compares them against build-time parameters and reports a pass/fail/timeout status. Software, or a board-level LED/hold-off, reads that status to detect a bitstream/software mismatch before the CPU is released.

---
 rtl/sysid_checker_pkg.sv | 28 ++
 rtl/sysid_wait_timer.sv | 31 +++
 rtl/sysid_boot_checker.sv | 147 ++++++++++++++
 tb/tb_sysid_boot_checker.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sysid_checker_pkg.sv
// Shared types and constants for the system-ID boot checker.
package sysid_checker_pkg;

    localparam int unsigned DATA_W     = 32;
    localparam int unsigned WAIT_CNT_W = 16;

    localparam logic SYSID_ADDR_ID = 1'b0;
    localparam logic SYSID_ADDR_TS = 1'b1;

    localparam logic [DATA_W-1:0] DEFAULT_EXPECTED_ID        = 32'd0;
    localparam logic [DATA_W-1:0] DEFAULT_EXPECTED_TIMESTAMP = 32'd1487187390;
    localparam int unsigned       DEFAULT_TIMEOUT_CYCLES     = 255;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RD_ID  = 2'd1,
        RD_TS  = 2'd2,
        FINISH = 2'd3
    } state_e;

    typedef struct packed {
        logic id_ok;
        logic ts_ok;
        logic sysid_ok;
        logic timeout;
    } status_t;

endpackage

// File: rtl/sysid_wait_timer.sv
// Saturating stall counter; last_c flags the stall that reaches TIMEOUT_CYCLES.
module sysid_wait_timer
    import sysid_checker_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic clock,
    input  logic reset_n,
    input  logic clear,
    input  logic enable,
    output logic last_c
);

    localparam logic [WAIT_CNT_W-1:0] TC_VALUE = WAIT_CNT_W'(TIMEOUT_CYCLES - 1);

    logic [WAIT_CNT_W-1:0] count;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && (count != '1)) begin
            count <= count + WAIT_CNT_W'(1);
        end
    end

    // count holds the stalls already seen, so this stall is number count+1
    assign last_c = enable && (count >= TC_VALUE);

endmodule

// File: rtl/sysid_boot_checker.sv
// Avalon-MM master that reads the sysid slave (ID, timestamp) and checks both
// words against build-time constants.
module sysid_boot_checker
    import sysid_checker_pkg::*;
#(
    parameter logic [DATA_W-1:0] EXPECTED_ID        = DEFAULT_EXPECTED_ID,
    parameter logic [DATA_W-1:0] EXPECTED_TIMESTAMP = DEFAULT_EXPECTED_TIMESTAMP,
    parameter int unsigned       TIMEOUT_CYCLES     = DEFAULT_TIMEOUT_CYCLES,
    parameter bit                AUTO_START         = 1'b1
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              start,
    output logic              avm_address,
    output logic              avm_read,
    input  logic [DATA_W-1:0] avm_readdata,
    input  logic              avm_waitrequest,
    output logic              busy,
    output logic              done,
    output logic              id_ok,
    output logic              ts_ok,
    output logic              sysid_ok,
    output logic              timeout,
    output logic [DATA_W-1:0] captured_id,
    output logic [DATA_W-1:0] captured_ts
);

    state_e            state, state_d;
    status_t           status, status_d;
    logic              auto_pending, auto_d;
    logic              read_d, address_d, busy_d, done_d;
    logic [DATA_W-1:0] cap_id_d, cap_ts_d;
    logic              timer_clear, timer_enable, timer_last;
    logic              id_match, ts_match;

    assign id_match = (avm_readdata == EXPECTED_ID);
    assign ts_match = (avm_readdata == EXPECTED_TIMESTAMP);

    sysid_wait_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_wait_timer (
        .clock  (clock),
        .reset_n(reset_n),
        .clear  (timer_clear),
        .enable (timer_enable),
        .last_c (timer_last)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            status       <= '0;
            auto_pending <= AUTO_START;
            avm_read     <= 1'b0;
            avm_address  <= SYSID_ADDR_ID;
            busy         <= 1'b0;
            done         <= 1'b0;
            captured_id  <= '0;
            captured_ts  <= '0;
        end else begin
            state        <= state_d;
            status       <= status_d;
            auto_pending <= auto_d;
            avm_read     <= read_d;
            avm_address  <= address_d;
            busy         <= busy_d;
            done         <= done_d;
            captured_id  <= cap_id_d;
            captured_ts  <= cap_ts_d;
        end
    end

    // Outputs are computed one state ahead so they register alongside the state.
    always_comb begin
        state_d      = state;
        status_d     = status;
        auto_d       = auto_pending;
        read_d       = 1'b0;
        address_d    = avm_address;
        busy_d       = busy;
        done_d       = 1'b0;
        cap_id_d     = captured_id;
        cap_ts_d     = captured_ts;
        timer_clear  = 1'b0;
        timer_enable = 1'b0;

        case (state)
            IDLE: begin
                if (start || auto_pending) begin
                    state_d     = RD_ID;
                    auto_d      = 1'b0;
                    status_d    = '0;
                    busy_d      = 1'b1;
                    read_d      = 1'b1;
                    address_d   = SYSID_ADDR_ID;
                    timer_clear = 1'b1;
                end
            end
            RD_ID: begin
                read_d       = 1'b1;
                timer_enable = avm_waitrequest;
                if (!avm_waitrequest) begin
                    cap_id_d       = avm_readdata;
                    status_d.id_ok = id_match;
                    state_d        = RD_TS;
                    address_d      = SYSID_ADDR_TS;
                    timer_clear    = 1'b1;
                end else if (timer_last) begin
                    status_d = '{id_ok: 1'b0, ts_ok: 1'b0, sysid_ok: 1'b0, timeout: 1'b1};
                    read_d   = 1'b0;
                    done_d   = 1'b1;
                    state_d  = FINISH;
                end
            end
            RD_TS: begin
                read_d       = 1'b1;
                timer_enable = avm_waitrequest;
                if (!avm_waitrequest) begin
                    cap_ts_d          = avm_readdata;
                    status_d.ts_ok    = ts_match;
                    status_d.sysid_ok = status.id_ok && ts_match && !status.timeout;
                    read_d            = 1'b0;
                    done_d            = 1'b1;
                    state_d           = FINISH;
                end else if (timer_last) begin
                    status_d = '{id_ok: 1'b0, ts_ok: 1'b0, sysid_ok: 1'b0, timeout: 1'b1};
                    read_d   = 1'b0;
                    done_d   = 1'b1;
                    state_d  = FINISH;
                end
            end
            FINISH: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign id_ok    = status.id_ok;
    assign ts_ok    = status.ts_ok;
    assign sysid_ok = status.sysid_ok;
    assign timeout  = status.timeout;

endmodule

// File: tb/tb_sysid_boot_checker.sv
// Bench for sysid_boot_checker: vector table plus scoreboard on done, and
// hand-written sequences for timeout, ignored starts and mid-check reset.
module tb_sysid_boot_checker;
    import sysid_checker_pkg::*;

    localparam logic [31:0] TS_GOOD = 32'd1487187390;
    localparam int          BOUND   = 600;

    typedef struct {
        logic [31:0] id_val;
        logic [31:0] ts_val;
        int          stall_id;
        int          stall_ts;
        logic        id_ok;
        logic        ts_ok;
        logic        sysid_ok;
        int          latency;
    } vec_t;

    typedef struct {
        logic        id_ok;
        logic        ts_ok;
        logic        sysid_ok;
        logic        timeout;
        logic [31:0] cap_id;
        logic [31:0] cap_ts;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, start, start_t;
    logic [31:0] id_val, ts_val;
    int          stall_id, stall_ts, stall_id_t, stall_ts_t;
    int          scnt, scnt_t;

    logic        addr, rd, wreq, busy, done, id_ok, ts_ok, sysid_ok, timeout;
    logic [31:0] rdata, cap_id, cap_ts;
    logic        addr_t, rd_t, wreq_t, busy_t, done_t, id_ok_t, ts_ok_t, sysid_ok_t, timeout_t;
    logic [31:0] rdata_t, cap_id_t, cap_ts_t;

    int   tests = 0;
    int   fails = 0;
    int   done_cnt = 0;
    exp_t exp_q[$];
    exp_t mon_e;
    logic prev_stall = 1'b0;
    logic prev_addr = 1'b0;
    vec_t vecs[6];

    sysid_boot_checker dut (
        .clock(clk), .reset_n(rst_n), .start(start),
        .avm_address(addr), .avm_read(rd), .avm_readdata(rdata), .avm_waitrequest(wreq),
        .busy(busy), .done(done), .id_ok(id_ok), .ts_ok(ts_ok), .sysid_ok(sysid_ok),
        .timeout(timeout), .captured_id(cap_id), .captured_ts(cap_ts)
    );

    sysid_boot_checker #(.TIMEOUT_CYCLES(4), .AUTO_START(1'b0)) dut_t (
        .clock(clk), .reset_n(rst_n), .start(start_t),
        .avm_address(addr_t), .avm_read(rd_t), .avm_readdata(rdata_t), .avm_waitrequest(wreq_t),
        .busy(busy_t), .done(done_t), .id_ok(id_ok_t), .ts_ok(ts_ok_t), .sysid_ok(sysid_ok_t),
        .timeout(timeout_t), .captured_id(cap_id_t), .captured_ts(cap_ts_t)
    );

    // Slave models: stall each read for a programmable number of cycles.
    assign rdata   = addr ? ts_val : id_val;
    assign rdata_t = addr_t ? ts_val : id_val;
    assign wreq    = rd && (scnt < (addr ? stall_ts : stall_id));
    assign wreq_t  = rd_t && (scnt_t < (addr_t ? stall_ts_t : stall_id_t));

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scnt   <= 0;
            scnt_t <= 0;
        end else begin
            scnt   <= (rd && wreq) ? scnt + 1 : 0;
            scnt_t <= (rd_t && wreq_t) ? scnt_t + 1 : 0;
        end
    end

    task automatic check1(input string name, input logic act, input logic exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Wait (bounded) for done on the selected instance; lat counts cycles since the start edge.
    task automatic wait_done(input bit sel, input int lat0, output int lat);
        lat = lat0;
        while (!(sel ? done_t : done) && lat < BOUND) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic pulse_and_wait(input bit sel, output int lat);
        if (sel) start_t = 1'b1;
        else     start   = 1'b1;
        @(negedge clk);
        start   = 1'b0;
        start_t = 1'b0;
        wait_done(sel, 1, lat);
    endtask

    // Scoreboard: every done pulse on the main instance pops one expectation.
    always @(negedge clk) begin
        if (rst_n && done) begin
            done_cnt++;
            if (exp_q.size() == 0) begin
                check1("unexpected_done", done, 1'b0);
            end else begin
                mon_e = exp_q.pop_front();
                check1("sb_id_ok", id_ok, mon_e.id_ok);
                check1("sb_ts_ok", ts_ok, mon_e.ts_ok);
                check1("sb_sysid_ok", sysid_ok, mon_e.sysid_ok);
                check1("sb_timeout", timeout, mon_e.timeout);
                check32("sb_captured_id", cap_id, mon_e.cap_id);
                check32("sb_captured_ts", cap_ts, mon_e.cap_ts);
                check1("sb_read_low_at_done", rd, 1'b0);
            end
        end
        if (rst_n && prev_stall) check1("addr_stable_in_stall", addr, prev_addr);
        prev_stall = rst_n && rd && wreq;
        prev_addr  = addr;
    end

    initial begin
        int lat;
        int dc;

        vecs[0] = '{32'd0,        TS_GOOD,                 0, 0, 1'b1, 1'b1, 1'b1, 3};
        vecs[1] = '{32'd0,        32'd1487187391,          0, 0, 1'b1, 1'b0, 1'b0, 3};
        vecs[2] = '{32'd5,        TS_GOOD,                 0, 0, 1'b0, 1'b1, 1'b0, 3};
        vecs[3] = '{32'd0,        TS_GOOD,                 3, 3, 1'b1, 1'b1, 1'b1, 9};
        vecs[4] = '{32'hFFFFFFFF, 32'd0,                   1, 0, 1'b0, 1'b0, 1'b0, 4};
        vecs[5] = '{32'd0,        TS_GOOD ^ 32'h80000000,  0, 2, 1'b1, 1'b0, 1'b0, 5};

        rst_n = 1'b0; start = 1'b0; start_t = 1'b0;
        id_val = 32'd0; ts_val = TS_GOOD;
        stall_id = 0; stall_ts = 0; stall_id_t = 0; stall_ts_t = 0;
        exp_q.push_back('{1'b1, 1'b1, 1'b1, 1'b0, 32'd0, TS_GOOD});
        repeat (3) @(negedge clk);

        check1("rst_read", rd, 1'b0);
        check1("rst_address", addr, 1'b0);
        check1("rst_busy", busy, 1'b0);
        check1("rst_done", done, 1'b0);
        check1("rst_sysid_ok", sysid_ok, 1'b0);
        check1("rst_timeout", timeout, 1'b0);
        check32("rst_captured_ts", cap_ts, 32'd0);

        // Auto-start after reset release
        rst_n = 1'b1;
        @(negedge clk);
        check1("auto_c1_read", rd, 1'b1);
        check1("auto_c1_addr", addr, 1'b0);
        check1("auto_c1_busy", busy, 1'b1);
        check1("noauto_c1_busy", busy_t, 1'b0);
        @(negedge clk);
        check1("auto_c2_read", rd, 1'b1);
        check1("auto_c2_addr", addr, 1'b1);
        @(negedge clk);
        check1("auto_c3_done", done, 1'b1);
        check1("auto_c3_busy", busy, 1'b1);
        @(negedge clk);
        check1("auto_c4_done", done, 1'b0);
        check1("auto_c4_busy", busy, 1'b0);

        foreach (vecs[i]) begin
            id_val   = vecs[i].id_val;
            ts_val   = vecs[i].ts_val;
            stall_id = vecs[i].stall_id;
            stall_ts = vecs[i].stall_ts;
            exp_q.push_back('{vecs[i].id_ok, vecs[i].ts_ok, vecs[i].sysid_ok, 1'b0,
                              vecs[i].id_val, vecs[i].ts_val});
            @(negedge clk);
            pulse_and_wait(1'b0, lat);
            check_int($sformatf("vec%0d_latency", i), lat, vecs[i].latency);
        end
        id_val = 32'd0; ts_val = TS_GOOD; stall_id = 0; stall_ts = 0;

        // Timeout instance: good check, ID stuck, TS stuck, then 3-cycle stalls
        @(negedge clk);
        pulse_and_wait(1'b1, lat);
        check_int("t_good_latency", lat, 3);
        check1("t_good_sysid_ok", sysid_ok_t, 1'b1);

        stall_id_t = 1000;
        @(negedge clk);
        pulse_and_wait(1'b1, lat);
        check_int("t_id_stuck_latency", lat, 5);
        check1("t_id_stuck_timeout", timeout_t, 1'b1);
        check1("t_id_stuck_id_ok", id_ok_t, 1'b0);
        check1("t_id_stuck_sysid_ok", sysid_ok_t, 1'b0);
        check1("t_id_stuck_read", rd_t, 1'b0);
        check32("t_id_stuck_cap_ts_kept", cap_ts_t, TS_GOOD);

        stall_id_t = 0; stall_ts_t = 1000; ts_val = 32'h1234;
        @(negedge clk);
        pulse_and_wait(1'b1, lat);
        check_int("t_ts_stuck_latency", lat, 6);
        check1("t_ts_stuck_timeout", timeout_t, 1'b1);
        check1("t_ts_stuck_id_ok_forced", id_ok_t, 1'b0);
        check1("t_ts_stuck_ts_ok", ts_ok_t, 1'b0);
        check32("t_ts_stuck_cap_ts_kept", cap_ts_t, TS_GOOD);

        stall_id_t = 3; stall_ts_t = 3; ts_val = TS_GOOD;
        @(negedge clk);
        pulse_and_wait(1'b1, lat);
        check_int("t_three_stalls_latency", lat, 9);
        check1("t_three_stalls_timeout", timeout_t, 1'b0);
        check1("t_three_stalls_sysid_ok", sysid_ok_t, 1'b1);
        stall_id_t = 0; stall_ts_t = 0;

        // start held during RD_TS and FINISH is dropped
        dc = done_cnt;
        exp_q.push_back('{1'b1, 1'b1, 1'b1, 1'b0, 32'd0, TS_GOOD});
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        start = 1'b1;
        check1("ign_rdts_addr", addr, 1'b1);
        @(negedge clk);
        check1("ign_finish_done", done, 1'b1);
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        check_int("ign_single_done", done_cnt - dc, 1);
        check1("ign_idle_busy", busy, 1'b0);

        // Restart in the cycle right after done
        exp_q.push_back('{1'b1, 1'b1, 1'b1, 1'b0, 32'd0, TS_GOOD});
        exp_q.push_back('{1'b1, 1'b1, 1'b1, 1'b0, 32'd0, TS_GOOD});
        pulse_and_wait(1'b0, lat);
        check_int("restart_first_latency", lat, 3);
        @(negedge clk);
        pulse_and_wait(1'b0, lat);
        check_int("restart_second_latency", lat, 3);

        // Reset asserted while the timestamp read is stalled
        stall_ts = 2;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        check1("midrst_pre_read", rd, 1'b1);
        check1("midrst_pre_addr", addr, 1'b1);
        check1("midrst_pre_id_ok", id_ok, 1'b1);
        #1 rst_n = 1'b0;
        #1;
        check1("midrst_read", rd, 1'b0);
        check1("midrst_addr", addr, 1'b0);
        check1("midrst_busy", busy, 1'b0);
        check1("midrst_id_ok", id_ok, 1'b0);
        check1("midrst_done", done, 1'b0);
        check32("midrst_cap_ts", cap_ts, 32'd0);
        stall_ts = 0;
        exp_q.push_back('{1'b1, 1'b1, 1'b1, 1'b0, 32'd0, TS_GOOD});
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        wait_done(1'b0, 0, lat);
        check_int("midrst_rerun_latency", lat, 3);

        repeat (3) @(negedge clk);
        check_int("scoreboard_drained", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
